// File: rtl/btn_single_pulse.sv
// btn_single_pulse
//   Debounces a raw active-low push-button and turns each accepted press into
//   a single-cycle pulse. It also provides the debounced level, a release
//   pulse and a wrapping press counter. The LED stage uses press_pulse as its
//   toggle event.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a change (>= 1)
//   CNT_W           : width of press_count
// Ports
//   clk           : single clock, all logic on posedge
//   rst_n         : synchronous active-low reset
//   btn_n         : raw button, async to clk, 0 = pressed, bouncy
//   btn_level     : debounced state, 1 = pressed
//   press_pulse   : one-cycle high per accepted press
//   release_pulse : one-cycle high per accepted release
//   press_count   : accepted presses modulo 2^CNT_W

`ifndef BSP_DEBOUNCE_DEFAULT
`ifdef SIMULATION
`define BSP_DEBOUNCE_DEFAULT 4
`else
`define BSP_DEBOUNCE_DEFAULT 1000000
`endif
`endif

module btn_single_pulse #(
  parameter int DEBOUNCE_CYCLES = `BSP_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Two-flop synchronizer as a small shift register; idles at released (1).
  logic [1:0] sync_pipe;
  logic       raw_s;

  state_t           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             level_d, press_d, rel_d;
  logic [CNT_W-1:0] count_d;

  assign raw_s = ~sync_pipe[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe     <= 2'b11;
      state_q       <= RELEASED;
      cnt_q         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      sync_pipe     <= {sync_pipe[0], btn_n};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      press_count   <= count_d;
    end
  end

  // Pulses default low every cycle, so each is high only in the cycle after
  // the accepting edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = btn_level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    count_d = press_count;
    case (state_q)
      RELEASED: begin
        if (raw_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!raw_s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = press_count + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!raw_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (raw_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

endmodule

// File: tb/tb_btn_single_pulse.sv
// Scoreboard bench for btn_single_pulse (DEBOUNCE_CYCLES=4, CNT_W=8).
// Stimulus pushes each expected pulse (kind, cycle, count, level) into a
// queue; the monitor pops on every pulse the DUT shows and flags pulses that
// are unexpected or overdue.

module tb_btn_single_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       btn_level, press_pulse, release_pulse;
  logic [7:0] press_count;

  btn_single_pulse #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rel;
    int         cyc;
    logic [7:0] cnt;
    logic       lvl;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   cyc = 0;
  int   vec = 0;
  int   err = 0;
  int   n_press = 0;
  int   n_rel = 0;
  int   exp_cnt = 0;

  always @(posedge clk) cyc++;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
      vec++;
      if (press_pulse === 1'b1) n_press++;
      if (release_pulse === 1'b1) n_rel++;
      if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
        err++;
        $display("FAIL both_pulses cyc=%0d press=1 release=1, required at most one", cyc);
      end else if (q.size() == 0) begin
        err++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b, required none", cyc, press_pulse, release_pulse);
      end else begin
        m = q.pop_front();
        if (m.rel !== release_pulse || m.cyc != cyc || m.cnt !== press_count || m.lvl !== btn_level) begin
          err++;
          $display("FAIL pulse got rel=%b cyc=%0d cnt=%0d lvl=%b required rel=%b cyc=%0d cnt=%0d lvl=%b",
                   release_pulse, cyc, press_count, btn_level, m.rel, m.cyc, m.cnt, m.lvl);
        end
      end
    end else if (q.size() != 0 && q[0].cyc < cyc) begin
      vec++;
      err++;
      m = q.pop_front();
      $display("FAIL missing_pulse rel=%b required at cyc=%0d, absent at cyc=%0d", m.rel, m.cyc, cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      err++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  // Next posedge is E0; acceptance at E6, visible at the negedge after it.
  task automatic do_press();
    btn_n   = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    q.push_back('{1'b0, cyc + 7, 8'(exp_cnt), 1'b1});
  endtask

  task automatic do_release();
    btn_n = 1'b1;
    q.push_back('{1'b1, cyc + 7, 8'(exp_cnt), 1'b0});
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_level"},   32'(btn_level),     0);
    chk({name, "_press"},   32'(press_pulse),   0);
    chk({name, "_release"}, 32'(release_pulse), 0);
    chk({name, "_count"},   32'(press_count),   0);
  endtask

  initial begin
    int p0, r0;
    rst_n = 1'b0;
    btn_n = 1'b1;
    tick(3);
    chk_idle("reset");
    rst_n = 1'b1;
    tick(50);
    chk_idle("idle50");

    // Clean press held 20 cycles, then clean release.
    do_press();
    tick(20);
    chk("clean_level", 32'(btn_level), 1);
    chk("clean_count", 32'(press_count), 1);
    do_release();
    tick(20);
    chk("release_level", 32'(btn_level), 0);
    chk("release_count", 32'(press_count), 1);

    // Bouncy press: low 3, high 1, low 2, high 1, then low held.
    btn_n = 1'b0; tick(3);
    btn_n = 1'b1; tick(1);
    btn_n = 1'b0; tick(2);
    btn_n = 1'b1; tick(1);
    do_press();
    tick(20);
    chk("bounce_count", 32'(press_count), 2);

    // Release with a 2-cycle low glitch inside RELEASE_WAIT.
    btn_n = 1'b1; tick(3);
    btn_n = 1'b0; tick(2);
    chk("glitch_level", 32'(btn_level), 1);
    do_release();
    tick(20);
    chk("glitch_rel_level", 32'(btn_level), 0);

    // Wrap: fresh reset, then 256 press/release pairs.
    rst_n = 1'b0;
    tick(2);
    rst_n   = 1'b1;
    exp_cnt = 0;
    tick(5);
    p0 = n_press;
    r0 = n_rel;
    for (int i = 0; i < 256; i++) begin
      do_press();
      tick(8);
      do_release();
      tick(8);
    end
    tick(4);
    chk("wrap_press_n", 32'(n_press - p0), 256);
    chk("wrap_rel_n", 32'(n_rel - r0), 256);
    chk("wrap_count", 32'(press_count), 0);

    // Reset mid PRESS_WAIT with the button held low.
    btn_n = 1'b0;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_idle("midreset");
    exp_cnt = 0;
    do_press();
    tick(20);
    chk("midreset_count", 32'(press_count), 1);
    chk("midreset_level", 32'(btn_level), 1);

    for (int i = 0; i < 100 && q.size() != 0; i++) tick(1);
    chk("queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
